// File: rtl/uart_pkg.sv
// Shared UART register map, STATUS bit positions and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Register select, taken from addr_i[2]
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS register bit positions
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_OVERRUN  = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // RX_WAIT parks the receiver after a framing error until the line is high again
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head output, used for both UART directions.
// Latency: a pushed word is visible at data_o the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens the same cycle; pop while empty is ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers, TX and RX FIFOs, TX/RX bit engines.
// Latency: ack_o and read data one cycle after capture; TX start bit two cycles after a write to an idle UART.
// Backpressure: none on the bus (full TX FIFO drops, empty RX FIFO reads 0); RX overrun flagged when RX FIFO full.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [1:0]  sel_i,
  input  logic        rd_i,
  input  logic        we_i,
  output logic        ack_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);

  // Size and upper address/data bits are deliberately ignored
  logic unused_bus;
  assign unused_bus = ^{addr_i[31:3], addr_i[1:0], data_i[31:8], sel_i};

  // ---------------- bus side ----------------
  logic        busy_q, ack_q;
  logic [31:0] data_q, rd_data_d, status_w;
  logic        req, capture, is_wr, is_rd, sel_data;
  logic        tx_push, rx_pop, status_rd, ovr_set;
  logic        ovr_q, ovr_d;

  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;
  logic       tx_pop, rx_push;

  tx_state_e  tx_state_q, tx_state_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_meta_q, rx_sync_q, rx_prev_q;

  assign req       = rd_i | we_i;
  assign capture   = req & ~busy_q;
  assign is_wr     = we_i;             // write wins when both strobes are high
  assign is_rd     = rd_i & ~we_i;
  assign sel_data  = (addr_i[2] == REG_DATA);
  assign tx_push   = capture & is_wr & sel_data;
  assign rx_pop    = capture & is_rd & sel_data;
  assign status_rd = capture & is_rd & ~sel_data;

  // A byte completing into a full RX FIFO is lost unless a pop frees a slot this cycle
  assign ovr_set = rx_push & rx_full & ~rx_pop;
  assign ovr_d   = ovr_set | (ovr_q & ~status_rd);

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign tx_o   = tx_q;
  assign irq_o  = ~rx_empty | ovr_q;

  // STATUS register image and read-data mux for the capture cycle
  always_comb begin
    status_w = '0;
    status_w[ST_RX_NONEMPTY] = ~rx_empty;
    status_w[ST_TX_FULL]     = tx_full;
    status_w[ST_TX_IDLE]     = tx_empty & (tx_state_q == TX_IDLE);
    status_w[ST_RX_OVERRUN]  = ovr_q;
    rd_data_d = '0;
    if (rx_pop && !rx_empty) rd_data_d = {24'b0, rx_head};
    else if (status_rd)      rd_data_d = status_w;
  end

  // Bus handshake: busy holds from capture until both strobes drop
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      busy_q <= capture | (busy_q & req);
      ack_q  <= capture;
      data_q <= rd_data_d;
      ovr_q  <= ovr_d;
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .data_i  (data_i[7:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .data_i  (rx_shift_q),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // ---------------- transmitter ----------------
  // TX next-state: stop bit chains straight into the next start bit when data is queued
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_bit_d   = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the next state so tx_o is a clean register output
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // TX state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- receiver ----------------
  // RX next-state: midpoint start re-check, mid-bit sampling, framing-error hold-off
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == BAUD_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_bit_d   = '0;
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX synchronizer, edge-detect history and state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl at CLK_DIV = 8, FIFO_DEPTH = 16.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i, data_i, data_o;
  logic [1:0]  sel_i;
  logic        rd_i, we_i, ack_o, rx_i, tx_o, irq_o;

  int vectors = 0;
  int miscompares = 0;

  uart_ctrl #(.CLK_DIV(8), .FIFO_DEPTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .sel_i  (sel_i),
    .rd_i   (rd_i),
    .we_i   (we_i),
    .ack_o  (ack_o),
    .rx_i   (rx_i),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus access; returns read data seen with ack and the number of ack cycles seen
  task automatic bus(input logic r, input logic w, input logic a2, input logic [7:0] wd,
                     output logic [31:0] rdat, output int nack);
    rdat = 'x;
    nack = 0;
    @(negedge clk);
    rd_i = r; we_i = w;
    addr_i = {29'h1ABCDE00, a2, 2'b01};
    data_i = {24'hFFFFFF, wd};
    sel_i  = 2'b10;
    for (int i = 0; i < 8 && nack == 0; i++) begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        nack++;
        rdat = data_o;
      end
    end
    rd_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    if (ack_o !== 1'b0) nack++;
  endtask

  task automatic rd_chk(input string tag, input logic a2, input logic [31:0] exp);
    logic [31:0] d;
    int n;
    bus(1'b1, 1'b0, a2, 8'h00, d, n);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic a2, input logic [7:0] b, output int n);
    logic [31:0] d;
    bus(1'b0, 1'b1, a2, b, d, n);
  endtask

  // Drive one serial frame on rx_i, 8 clocks per bit, then a short idle
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx_i = f[k];
      repeat (7) @(negedge clk);
    end
    @(negedge clk);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Wait for a start bit on tx_o and sample each bit at its midpoint; gap = clocks waited
  task automatic tx_decode(output logic [9:0] f, output int gap);
    gap = 0;
    while (tx_o !== 1'b0 && gap < 2000) begin
      @(negedge clk);
      gap++;
    end
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 4 : 8) @(negedge clk);
      f[k] = tx_o;
    end
  endtask

  // Check first and last clock of every bit of one frame
  task automatic tx_exact(input logic [7:0] b);
    logic [9:0] f;
    int t;
    f = {1'b1, b, 1'b0};
    t = 0;
    while (tx_o !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 8 == 0 || c % 8 == 7)
        chk($sformatf("tx55_bit%0d_clk%0d", c / 8, c % 8), {31'b0, tx_o}, {31'b0, f[c / 8]});
    end
  endtask

  task automatic count_tx_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  f;
    int n, acks, gap, badgap, lows;

    // Reset with a STATUS read already pending
    rst = 1'b1; rx_i = 1'b1; sel_i = 2'b00; data_i = '0;
    addr_i = 32'h4; rd_i = 1'b1; we_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx_o}, 32'd1);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", {31'b0, ack_o}, 32'd1);
    chk("post_rst_status", data_o, 32'h4);
    rd_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ack_drop", {31'b0, ack_o}, 32'd0);

    // STATUS write: acked, no effect
    wr(1'b1, 8'hAA, n);
    chk("status_wr_ack", n, 1);
    rd_chk("status_after_wr", 1'b1, 32'h4);

    // Transmit 0x55
    wr(1'b0, 8'h55, n);
    chk("tx55_ack_once", n, 1);
    tx_exact(8'h55);

    // Receive 0xA3
    send_frame(8'hA3, 1'b1);
    chk("rxA3_irq", {31'b0, irq_o}, 32'd1);
    rd_chk("rxA3_status", 1'b1, 32'h5);
    rd_chk("rxA3_data", 1'b0, 32'hA3);
    rd_chk("rx_empty_read", 1'b0, 32'h0);
    chk("rx_irq_clear", {31'b0, irq_o}, 32'd0);

    // TX FIFO fill behind a busy shifter
    wr(1'b0, 8'hFF, n);
    acks = 0;
    for (int i = 0; i < 17; i++) begin
      wr(1'b0, 8'(8'h20 + i), n);
      acks += n;
    end
    chk("txfill_acks", acks, 17);
    rd_chk("txfill_status", 1'b1, 32'h2);
    badgap = 0;
    for (int i = 0; i < 16; i++) begin
      tx_decode(f, gap);
      chk($sformatf("txfill_frame%0d", i), {22'b0, f}, {22'b0, 1'b1, 8'(8'h20 + i), 1'b0});
      if (i > 0 && gap != 4) badgap++;
    end
    chk("txfill_backtoback", badgap, 0);
    count_tx_low(120, lows);
    chk("txfill_17th_dropped", lows, 0);
    rd_chk("txfill_idle", 1'b1, 32'h4);

    // RX overrun
    for (int i = 0; i < 17; i++) send_frame(8'(8'h40 + i), 1'b1);
    chk("ovr_irq", {31'b0, irq_o}, 32'd1);
    rd_chk("ovr_status1", 1'b1, 32'hD);
    rd_chk("ovr_status2", 1'b1, 32'h5);
    for (int i = 0; i < 16; i++)
      rd_chk($sformatf("ovr_data%0d", i), 1'b0, 32'(8'h40 + i));
    rd_chk("ovr_drained", 1'b0, 32'h0);
    rd_chk("ovr_status3", 1'b1, 32'h4);

    // Held read strobe pops once
    send_frame(8'h61, 1'b1);
    send_frame(8'h62, 1'b1);
    @(negedge clk);
    rd_i = 1'b1; addr_i = 32'h0;
    acks = 0; d = 'x;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        acks++;
        d = data_o;
      end
    end
    rd_i = 1'b0;
    @(negedge clk);
    chk("hold_acks", acks, 1);
    chk("hold_data", d, 32'h61);
    rd_chk("hold_next", 1'b0, 32'h62);
    rd_chk("hold_empty", 1'b0, 32'h0);

    // 3-clock glitch rejected, receiver still usable
    @(negedge clk);
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("glitch_status", 1'b1, 32'h4);
    send_frame(8'h3C, 1'b1);
    rd_chk("glitch_after", 1'b0, 32'h3C);

    // Framing error discards the byte
    send_frame(8'h77, 1'b0);
    repeat (4) @(negedge clk);
    rd_chk("badstop_status", 1'b1, 32'h4);
    send_frame(8'h5A, 1'b1);
    rd_chk("badstop_after", 1'b0, 32'h5A);

    // Both strobes high: treated as a write, RX untouched
    send_frame(8'h99, 1'b1);
    bus(1'b1, 1'b1, 1'b0, 8'hC3, d, n);
    chk("rdwe_ack", n, 1);
    chk("rdwe_rdata", d, 32'h0);
    tx_decode(f, gap);
    chk("rdwe_tx", {22'b0, f}, {22'b0, 1'b1, 8'hC3, 1'b0});
    rd_chk("rdwe_rx_kept", 1'b0, 32'h99);

    // Reset in the middle of a frame
    repeat (10) @(negedge clk);
    wr(1'b0, 8'h00, n);
    repeat (20) @(negedge clk);
    chk("midtx_low", {31'b0, tx_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midtx_rst_tx", {31'b0, tx_o}, 32'd1);
    chk("midtx_rst_irq", {31'b0, irq_o}, 32'd0);
    rst = 1'b0;
    count_tx_low(100, lows);
    chk("midtx_aborted", lows, 0);
    rd_chk("midtx_status", 1'b1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
